lab1_imul_resp_accum: RTL and testbench
=======================================

Name: lab1_imul_resp_accum

Overview:
- Downstream consumer of the integer multiplier's 32-bit product stream.
- Sums groups of consecutive products into one 32-bit result. The group length is programmable, and a group can be closed early by a flush.
- Emits each result with its product count and a sticky overflow flag over a val/rdy stream.
- Serves as the accumulate half of dot-product / MAC datapaths built on the multiplier.

Parameters:
- p_nbits, 32, width of products and of the sum.
- p_max_len, 16, maximum group length.
- p_len_nbits, $clog2(p_max_len+1), width of the length and count fields (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- cfg_len  input  p_len_nbits  group length; sampled only when a group's first product is accepted.
- flush  input  1  close the open group early.
- istream_val  input  1  product valid.
- istream_rdy  output  1  block can accept a product.
- istream_msg  input  p_nbits  product from the multiplier.
- ostream_val  output  1  result valid.
- ostream_rdy  input  1  sink accepts result.
- ostream_msg  output  p_nbits  accumulated sum.
- ostream_cnt  output  p_len_nbits  number of products in the sum.
- ostream_ovf  output  1  an unsigned carry-out occurred during the group.

Behaviour:
- Handshakes: input accept = istream_val & istream_rdy. Output fire = ostream_val & ostream_rdy.
- State machine has three states: IDLE, ACCUM, DONE.
- Registers: sum, cnt, len_reg, ovf. ostream_msg, ostream_cnt and ostream_ovf drive directly from sum, cnt and ovf.
- Reset (async, any time, including mid-group): state=IDLE, sum=0, cnt=0, len_reg=0, ovf=0.
  - ostream_val=0 immediately.
  - istream_rdy=0 while reset is asserted; 1 from the first cycle after deassertion.
  - The partial group is discarded.
- Group start, on an accept in IDLE, or on a start in DONE as described below:
  - sum<=msg, cnt<=1, ovf<=0.
  - len_reg <= (cfg_len==0 ? 1 : min(cfg_len, p_max_len)).
  - Next state is DONE if the effective length is 1 or flush=1; otherwise ACCUM.
- IDLE: istream_rdy=1, ostream_val=0. flush is ignored.
- ACCUM: istream_rdy=1, ostream_val=0.
  - On accept: sum<=sum+msg (mod 2^p_nbits); ovf<=ovf|carry_out; cnt<=cnt+1.
  - Go to DONE if cnt+1==len_reg, or if flush=1 in the same cycle (the accepted product is included).
  - flush=1 with no accept: go to DONE with the current sum and cnt.
  - cfg_len changes while in ACCUM have no effect.
- DONE: ostream_val=1. Outputs stay stable until fire.
  - istream_rdy = ostream_rdy; a combinational path from ostream_rdy is permitted.
  - On fire with no accept: go to IDLE.
  - On fire and accept in the same cycle: start a new group immediately, with no bubble.
  - flush is ignored.
- Latency: the result is valid in the cycle after the group's final product or flush. Sustained throughput is one product per cycle.
- Arithmetic: unsigned wrap-around. Overflow is sticky per group and clears at the next group start.
- cnt never exceeds len_reg. The sum is never emitted with cnt=0.

Test Plan:
- cfg_len=4; products 3,5,7,9 back-to-back; ostream_rdy=1 -> a single one-cycle output, msg=24, cnt=4, ovf=0, ostream_val asserted the cycle after the 4th accept.
- cfg_len=2; products 0xFFFFFFFF, 0x00000002 -> msg=0x00000001, cnt=2, ovf=1. The next group 1,1 -> msg=2, ovf=0.
- Backpressure:
  - Hold ostream_rdy=0 for 5 cycles in DONE -> ostream_val=1, msg stable, istream_rdy=0 throughout.
  - Then set ostream_rdy=1 with istream_val=1, msg=10 -> the result fires and a new group starts in the same cycle; the next result (cfg_len=1) is msg=10, cnt=1.
- cfg_len=8; accept 1,2,3, then flush with no val -> msg=6, cnt=3. Repeat with flush coincident with accepting 4 -> msg=10, cnt=4.
- cfg_len=0 and cfg_len=1 -> each product is emitted alone with cnt=1. Change cfg_len from 4 to 2 after the first product -> the group still closes at cnt=4.
- Async reset asserted between clock edges after 2 of 4 products -> ostream_val=0 and istream_rdy=0 immediately. After release, products 5,5,5,5 -> msg=20, cnt=4.

Source files
------------

// File: rtl/lab1_imul_resp_accum_if.sv
// Product-in / result-out stream bundle for the response accumulator.
// Both streams use val/rdy: a transfer happens in a cycle where val & rdy are high
// at the rising clock edge. Once val is high, the source holds val and its payload
// until that transfer. rdy may depend combinationally on the other side's signals.
interface lab1_imul_resp_accum_if #(
  parameter int p_nbits     = 32,
  parameter int p_len_nbits = 5
);
  logic                   istream_val;
  logic                   istream_rdy;
  logic [p_nbits-1:0]     istream_msg;
  logic                   ostream_val;
  logic                   ostream_rdy;
  logic [p_nbits-1:0]     ostream_msg;
  logic [p_len_nbits-1:0] ostream_cnt;
  logic                   ostream_ovf;

  // Environment side: produces products and consumes results.
  modport master (
    output istream_val, istream_msg, ostream_rdy,
    input  istream_rdy, ostream_val, ostream_msg, ostream_cnt, ostream_ovf
  );

  // Accumulator side.
  modport slave (
    input  istream_val, istream_msg, ostream_rdy,
    output istream_rdy, ostream_val, ostream_msg, ostream_cnt, ostream_ovf
  );
endinterface

// File: rtl/lab1_imul_resp_accum.sv
// Sums groups of consecutive multiplier products. A group closes at a programmable
// length or on a flush. Each result carries its product count and a sticky carry flag.
module lab1_imul_resp_accum #(
  parameter  int p_nbits     = 32,
  parameter  int p_max_len   = 16,
  localparam int p_len_nbits = $clog2(p_max_len + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [p_len_nbits-1:0] cfg_len,
  input  logic                   flush,
  lab1_imul_resp_accum_if.slave  io,
  output logic [1:0]             o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [p_nbits-1:0]     r_sum;
  logic [p_nbits-1:0]     w_sum_nxt;
  logic [p_len_nbits-1:0] r_cnt;
  logic [p_len_nbits-1:0] w_cnt_nxt;
  logic [p_len_nbits-1:0] r_len;
  logic [p_len_nbits-1:0] w_len_nxt;
  logic                   r_ovf;
  logic                   w_ovf_nxt;

  logic                   w_istream_rdy;
  logic                   w_ostream_val;
  logic                   w_accept;
  logic                   w_fire;
  logic                   w_start;
  logic [p_len_nbits-1:0] w_eff_len;
  logic [p_len_nbits-1:0] w_cnt_inc;
  logic [p_nbits:0]       w_add;

  // Holding reset also gates rdy so nothing is accepted while the block is cleared.
  assign w_ostream_val = (r_state == DONE);
  assign w_istream_rdy = !reset && ((r_state != DONE) || io.ostream_rdy);
  assign w_accept      = io.istream_val && w_istream_rdy;
  assign w_fire        = w_ostream_val && io.ostream_rdy;

  // A group opens on any accept in IDLE, or on an accept that coincides with
  // the result leaving DONE, which keeps a full-rate stream bubble-free.
  assign w_start = w_accept && ((r_state == IDLE) || ((r_state == DONE) && w_fire));

  // Length 0 behaves as 1; anything above the maximum is clamped.
  always_comb begin
    w_eff_len = cfg_len;
    if (cfg_len == '0) begin
      w_eff_len = p_len_nbits'(1);
    end else if (cfg_len > p_len_nbits'(p_max_len)) begin
      w_eff_len = p_len_nbits'(p_max_len);
    end
  end

  assign w_add     = {1'b0, r_sum} + {1'b0, io.istream_msg};
  assign w_cnt_inc = r_cnt + p_len_nbits'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_sum_nxt   = r_sum;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_ovf_nxt   = r_ovf;

    if (w_start) begin
      w_sum_nxt = io.istream_msg;
      w_cnt_nxt = p_len_nbits'(1);
      w_len_nxt = w_eff_len;
      w_ovf_nxt = 1'b0;
      if ((w_eff_len == p_len_nbits'(1)) || flush) begin
        w_state_nxt = DONE;
      end else begin
        w_state_nxt = ACCUM;
      end
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = IDLE;
        end
        ACCUM: begin
          if (w_accept) begin
            w_sum_nxt = w_add[p_nbits-1:0];
            w_ovf_nxt = r_ovf | w_add[p_nbits];
            w_cnt_nxt = w_cnt_inc;
            if ((w_cnt_inc == r_len) || flush) begin
              w_state_nxt = DONE;
            end
          end else if (flush) begin
            w_state_nxt = DONE;
          end
        end
        DONE: begin
          if (w_fire) begin
            w_state_nxt = IDLE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sum   <= w_sum_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign io.istream_rdy = w_istream_rdy;
  assign io.ostream_val = w_ostream_val;
  assign io.ostream_msg = r_sum;
  assign io.ostream_cnt = r_cnt;
  assign io.ostream_ovf = r_ovf;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_lab1_imul_resp_accum.sv
// Randomized and directed bench for lab1_imul_resp_accum, checked every cycle
// against a group-level model that sums whole product lists with wide arithmetic.
module tb_lab1_imul_resp_accum;

  localparam int W  = 32;
  localparam int LN = 5;
  localparam int ML = 16;
  localparam int QW = 1 + LN + W;

  logic          clk;
  logic          reset;
  logic [LN-1:0] cfg_len;
  logic          flush;
  logic [1:0]    dbg_state;

  lab1_imul_resp_accum_if #(.p_nbits(W), .p_len_nbits(LN)) io ();

  lab1_imul_resp_accum #(.p_nbits(W), .p_max_len(ML)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_len     (cfg_len),
    .flush       (flush),
    .io          (io.slave),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model / scoreboard ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  logic [QW-1:0] exp_q[$];
  logic [W-1:0]  grp_q[$];
  bit            grp_open = 0;
  int            grp_len  = 0;

  function automatic int eff_len(input logic [LN-1:0] c);
    if (c == 0) return 1;
    if (int'(c) > ML) return ML;
    return int'(c);
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    grp_q.delete();
    grp_open = 0;
    grp_len  = 0;
  endfunction

  // Result of a group is the plain sum; a carry occurred iff the true sum exceeds 32 bits.
  function automatic void close_group();
    longint unsigned total;
    logic [LN-1:0]   cnt;
    logic [W-1:0]    low;
    total = 0;
    foreach (grp_q[i]) total += longint'(grp_q[i]);
    cnt = LN'(grp_q.size());
    low = total[W-1:0];
    exp_q.push_back({(total >> W) != 0, cnt, low});
    grp_q.delete();
    grp_open = 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic val, input logic [W-1:0] msg,
                       input logic fl, input logic ordy);
    io.istream_val = val;
    io.istream_msg = msg;
    flush          = fl;
    io.ostream_rdy = ordy;
  endtask

  // One clock: check outputs at the falling edge, advance the model, land at posedge+1.
  task automatic step();
    logic          exp_val;
    logic          exp_rdy;
    logic          fire;
    logic          acc;
    logic [QW-1:0] got;
    @(negedge clk);
    exp_val = (exp_q.size() != 0);
    exp_rdy = exp_val ? io.ostream_rdy : 1'b1;
    n_checks++;
    if (io.istream_rdy !== exp_rdy) begin
      n_errors++;
      $display("FAIL istream_rdy @%0t: got %b expected %b", $time, io.istream_rdy, exp_rdy);
    end
    n_checks++;
    if (io.ostream_val !== exp_val) begin
      n_errors++;
      $display("FAIL ostream_val @%0t: got %b expected %b", $time, io.ostream_val, exp_val);
    end
    if (exp_val) begin
      got = {io.ostream_ovf, io.ostream_cnt, io.ostream_msg};
      n_checks++;
      if (got !== exp_q[0]) begin
        n_errors++;
        $display("FAIL result @%0t: got ovf=%b cnt=%0d msg=%h expected ovf=%b cnt=%0d msg=%h",
                 $time, got[QW-1], got[W+LN-1:W], got[W-1:0],
                 exp_q[0][QW-1], exp_q[0][W+LN-1:W], exp_q[0][W-1:0]);
      end
    end
    fire = exp_val && io.ostream_rdy;
    acc  = io.istream_val && exp_rdy;
    if (fire) void'(exp_q.pop_front());
    if (acc) begin
      if (!grp_open) begin
        grp_open = 1;
        grp_len  = eff_len(cfg_len);
        grp_q.delete();
      end
      grp_q.push_back(io.istream_msg);
      if (grp_q.size() == grp_len || flush) close_group();
    end else if (flush && grp_open) begin
      close_group();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] msg);
    drive(1'b1, msg, 1'b0, 1'b1);
    step();
  endtask

  task automatic drain();
    drive(1'b0, '0, 1'b0, 1'b1);
    repeat (3) step();
  endtask

  task automatic expect_now(input string name, input logic [W-1:0] msg,
                            input logic [LN-1:0] cnt, input logic ovf);
    n_checks++;
    if (io.ostream_val !== 1'b1 || io.ostream_msg !== msg ||
        io.ostream_cnt !== cnt || io.ostream_ovf !== ovf) begin
      n_errors++;
      $display("FAIL %s: got val=%b msg=%h cnt=%0d ovf=%b expected val=1 msg=%h cnt=%0d ovf=%b",
               name, io.ostream_val, io.ostream_msg, io.ostream_cnt, io.ostream_ovf,
               msg, cnt, ovf);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset   = 1'b1;
    cfg_len = LN'(4);
    drive(1'b0, '0, 1'b0, 1'b1);
    #3;
    n_checks++;
    if (io.ostream_val !== 1'b0 || io.istream_rdy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_hs: got val=%b rdy=%b expected val=0 rdy=0",
               io.ostream_val, io.istream_rdy);
    end
    n_checks++;
    if ({io.ostream_ovf, io.ostream_cnt, io.ostream_msg} !== '0) begin
      n_errors++;
      $display("FAIL reset_regs: got ovf=%b cnt=%0d msg=%h expected all zero",
               io.ostream_ovf, io.ostream_cnt, io.ostream_msg);
    end
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    model_clear();
    step();
  endtask

  task automatic test_basic();
    cfg_len = LN'(4);
    send(32'd3);
    send(32'd5);
    send(32'd7);
    send(32'd9);
    expect_now("basic_sum", 32'd24, LN'(4), 1'b0);
    drain();
  endtask

  task automatic test_overflow();
    cfg_len = LN'(2);
    send(32'hFFFF_FFFF);
    send(32'h0000_0002);
    expect_now("ovf_set", 32'h1, LN'(2), 1'b1);
    drain();
    send(32'd1);
    send(32'd1);
    expect_now("ovf_clear", 32'd2, LN'(2), 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    cfg_len = LN'(1);
    send(32'd77);
    drive(1'b1, 32'd99, 1'b0, 1'b0);
    repeat (5) step();
    cfg_len = LN'(1);
    drive(1'b1, 32'd10, 1'b0, 1'b1);
    step();
    expect_now("bp_restart", 32'd10, LN'(1), 1'b0);
    drain();
    for (int i = 0; i < 6; i++) send(32'(i * 3 + 1));
    drain();
  endtask

  task automatic test_flush();
    cfg_len = LN'(8);
    send(32'd1);
    send(32'd2);
    send(32'd3);
    drive(1'b0, '0, 1'b1, 1'b1);
    step();
    expect_now("flush_idle", 32'd6, LN'(3), 1'b0);
    drain();
    send(32'd1);
    send(32'd2);
    send(32'd3);
    drive(1'b1, 32'd4, 1'b1, 1'b1);
    step();
    expect_now("flush_accept", 32'd10, LN'(4), 1'b0);
    drain();
    drive(1'b0, '0, 1'b1, 1'b1);
    repeat (2) step();
    drain();
  endtask

  task automatic test_lengths();
    cfg_len = LN'(0);
    send(32'd11);
    send(32'd12);
    cfg_len = LN'(1);
    send(32'd13);
    send(32'd14);
    drain();
    cfg_len = LN'(4);
    send(32'd1);
    cfg_len = LN'(2);
    send(32'd2);
    send(32'd3);
    send(32'd4);
    expect_now("len_latched", 32'd10, LN'(4), 1'b0);
    drain();
    cfg_len = LN'(31);
    for (int i = 0; i < ML; i++) send(32'(i + 1));
    expect_now("len_clamp", 32'd136, LN'(16), 1'b0);
    drain();
  endtask

  task automatic test_async_reset();
    cfg_len = LN'(4);
    send(32'd1);
    send(32'd2);
    drive(1'b0, '0, 1'b0, 1'b1);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    n_checks++;
    if (io.ostream_val !== 1'b0 || io.istream_rdy !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: got val=%b rdy=%b expected val=0 rdy=0",
               io.ostream_val, io.istream_rdy);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) send(32'd5);
    expect_now("post_reset", 32'd20, LN'(4), 1'b0);
    drain();
  endtask

  task automatic test_random();
    logic          val;
    logic [W-1:0]  msg;
    logic          fl;
    logic          ordy;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) cfg_len = LN'($urandom_range(0, 20));
      val  = ($urandom_range(0, 3) != 0);
      msg  = ($urandom_range(0, 1) == 0) ? $urandom : W'($urandom_range(0, 15));
      fl   = ($urandom_range(0, 7) == 0);
      ordy = ($urandom_range(0, 3) != 0);
      drive(val, msg, fl, ordy);
      step();
    end
    drive(1'b0, '0, 1'b1, 1'b1);
    repeat (2) step();
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_flush();
    test_lengths();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
